// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store path: access sizes, engine
// states, default bus timeout and the alignment rule.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } mau_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 32'd255;

    function automatic logic is_aligned(input mem_size_e sz, input logic [1:0] lo);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (lo[0] == 1'b0);
            SZ_WORD: ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane logic: byte-enable generation, store-data replication
// and load-data extraction with sign/zero extension.
module mem_lane_fmt
    import mips_mem_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_fmt
);

    logic [31:0] shifted_s;

    assign shifted_s = rdata >> {addr_lo, 3'b000};

    // Store side: enables and lane replication
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    // Load side: pick the addressed lane and extend
    always_comb begin
        rdata_fmt = 32'h0000_0000;
        case (size)
            SZ_BYTE: rdata_fmt = {{24{sign_ext & shifted_s[7]}}, shifted_s[7:0]};
            SZ_HALF: rdata_fmt = {{16{sign_ext & shifted_s[15]}}, shifted_s[15:0]};
            SZ_WORD: rdata_fmt = shifted_s;
            default: rdata_fmt = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one handshaked data-memory access per request,
// stalling EX/MEM until completion, with alignment and timeout protection.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        is_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        mem_stall,
    output logic        align_err,
    output logic        bus_timeout
);

    // Wait counter value during the last ACCESS cycle allowed before abort
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 32'd1);

    mau_state_e  state_r;
    mau_state_e  state_s;

    logic [31:0] lat_addr_r;
    logic        lat_we_r;
    mem_size_e   lat_size_r;
    logic        lat_sext_r;
    logic [3:0]  lat_be_r;
    logic [31:0] lat_wdata_r;
    logic [7:0]  wait_cnt_r;
    logic [31:0] load_data_r;
    logic        load_valid_r;
    logic        bus_timeout_r;

    mem_size_e   req_size_s;
    mem_size_e   fmt_size_s;
    logic [1:0]  fmt_addr_lo_s;
    logic        aligned_s;
    logic        accept_s;
    logic        timeout_hit_s;
    logic [3:0]  fmt_be_s;
    logic [31:0] fmt_wdata_s;
    logic [31:0] fmt_load_s;

    assign req_size_s    = mem_size_e'(size);
    assign aligned_s     = is_aligned(req_size_s, addr[1:0]);
    assign accept_s      = (state_r == ST_IDLE) && req_valid && aligned_s;
    assign timeout_hit_s = (wait_cnt_r == TO_LAST);

    // The formatter sees the live request in IDLE and the latched one afterwards
    assign fmt_size_s    = (state_r == ST_IDLE) ? req_size_s : lat_size_r;
    assign fmt_addr_lo_s = (state_r == ST_IDLE) ? addr[1:0]  : lat_addr_r[1:0];

    mem_lane_fmt u_lane_fmt (
        .size      (fmt_size_s),
        .addr_lo   (fmt_addr_lo_s),
        .sign_ext  (lat_sext_r),
        .wdata     (wdata),
        .rdata     (dmem_rdata),
        .be        (fmt_be_s),
        .wdata_rep (fmt_wdata_s),
        .rdata_fmt (fmt_load_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an ack in the final allowed cycle beats the timeout
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_ACCESS;
                else          state_s = ST_IDLE;
            end
            ST_ACCESS: begin
                if (dmem_ack)           state_s = ST_DONE;
                else if (timeout_hit_s) state_s = ST_IDLE;
                else                    state_s = ST_ACCESS;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Handshake and pipeline-control outputs
    always_comb begin
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        mem_stall = 1'b0;
        align_err = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rst && req_valid) begin
                    mem_stall = aligned_s;
                    align_err = ~aligned_s;
                end else begin
                    mem_stall = 1'b0;
                    align_err = 1'b0;
                end
            end
            ST_ACCESS: begin
                dmem_req  = 1'b1;
                dmem_we   = lat_we_r;
                mem_stall = 1'b1;
            end
            default: begin
                dmem_req  = 1'b0;
                dmem_we   = 1'b0;
                mem_stall = 1'b0;
                align_err = 1'b0;
            end
        endcase
    end

    // Request latches, wait counter and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr_r    <= 32'h0000_0000;
            lat_we_r      <= 1'b0;
            lat_size_r    <= SZ_BYTE;
            lat_sext_r    <= 1'b0;
            lat_be_r      <= 4'b0000;
            lat_wdata_r   <= 32'h0000_0000;
            wait_cnt_r    <= 8'd0;
            load_data_r   <= 32'h0000_0000;
            load_valid_r  <= 1'b0;
            bus_timeout_r <= 1'b0;
        end else begin
            load_valid_r  <= 1'b0;
            bus_timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        lat_addr_r  <= addr;
                        lat_we_r    <= is_write;
                        lat_size_r  <= req_size_s;
                        lat_sext_r  <= sign_ext;
                        lat_be_r    <= fmt_be_s;
                        lat_wdata_r <= fmt_wdata_s;
                        wait_cnt_r  <= 8'd0;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        if (!lat_we_r) begin
                            load_data_r  <= fmt_load_s;
                            load_valid_r <= 1'b1;
                        end
                    end else if (timeout_hit_s) begin
                        bus_timeout_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                default: begin
                    wait_cnt_r <= wait_cnt_r;
                end
            endcase
        end
    end

    assign dmem_addr   = {lat_addr_r[31:2], 2'b00};
    assign dmem_be     = lat_be_r;
    assign dmem_wdata  = lat_wdata_r;
    assign load_data   = load_data_r;
    assign load_valid  = load_valid_r;
    assign bus_timeout = bus_timeout_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-lane
// reference model computed with plain arithmetic.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        is_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        mem_stall;
    logic        align_err;
    logic        bus_timeout;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_load;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .is_write    (is_write),
        .size        (size),
        .sign_ext    (sign_ext),
        .addr        (addr),
        .wdata       (wdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .mem_stall   (mem_stall),
        .align_err   (align_err),
        .bus_timeout (bus_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete request; entered and left 1 time unit after a rising edge in IDLE.
    // dly = number of ACCESS cycles before the ack cycle (ack in ACCESS cycle dly+1).
    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int dly, input logic spurious);
        int          nb;
        logic        ok;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] eld;
        logic [63:0] v;
        logic [63:0] m;
        logic        acked;

        nb  = 1 << sz;
        ok  = (sz != 2'd3) && ((a % nb) == 0);
        ebe = 4'(((1 << nb) - 1) << a[1:0]);
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
        v = 64'(rd) >> (8 * a[1:0]);
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = v & m;
        if (sx && v[8*nb-1]) v = v | ~m;
        eld = v[31:0];

        req_valid = 1'b1; is_write = wr; size = sz; sign_ext = sx; addr = a; wdata = wd;
        #1;
        if (!ok) begin
            check("align_err_pulse", 32'(align_err), 32'd1);
            check("align_no_stall", 32'(mem_stall), 32'd0);
            check("align_no_req", 32'(dmem_req), 32'd0);
            step();
            check("align_no_req_next", 32'(dmem_req), 32'd0);
            req_valid = 1'b0;
            #1;
            check("align_err_clear", 32'(align_err), 32'd0);
            return;
        end
        check("accept_stall", 32'(mem_stall), 32'd1);
        check("accept_no_err", 32'(align_err), 32'd0);
        check("accept_no_req", 32'(dmem_req), 32'd0);
        step();
        acked = 1'b0;
        for (int k = 1; k <= int'(TO) && !acked; k++) begin
            check("acc_req", 32'(dmem_req), 32'd1);
            check("acc_stall", 32'(mem_stall), 32'd1);
            check("acc_we", 32'(dmem_we), 32'(wr));
            check("acc_addr", dmem_addr, {a[31:2], 2'b00});
            check("acc_be", 32'(dmem_be), 32'(ebe));
            check("acc_wdata", dmem_wdata, ewd);
            if (k == dly + 1) begin
                dmem_ack = 1'b1;
                dmem_rdata = rd;
                acked = 1'b1;
            end
            step();
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
        end
        if (acked) begin
            if (!wr) model_load = eld;
            check("done_no_req", 32'(dmem_req), 32'd0);
            check("done_no_stall", 32'(mem_stall), 32'd0);
            check("done_load_valid", 32'(load_valid), 32'(!wr));
            check("done_load_data", load_data, model_load);
            check("done_no_timeout", 32'(bus_timeout), 32'd0);
            req_valid = 1'b0;
            step();
            check("idle_lv_clear", 32'(load_valid), 32'd0);
            if (spurious) begin
                dmem_ack = 1'b1;
                dmem_rdata = $urandom;
                step();
                dmem_ack = 1'b0;
                check("stray_ack_no_req", 32'(dmem_req), 32'd0);
                check("stray_ack_no_lv", 32'(load_valid), 32'd0);
                check("stray_ack_data", load_data, model_load);
            end
        end else begin
            req_valid = 1'b0;
            #1;
            check("timeout_pulse", 32'(bus_timeout), 32'd1);
            check("timeout_no_stall", 32'(mem_stall), 32'd0);
            check("timeout_no_req", 32'(dmem_req), 32'd0);
            check("timeout_no_lv", 32'(load_valid), 32'd0);
            check("timeout_data_kept", load_data, model_load);
            step();
            check("timeout_clear", 32'(bus_timeout), 32'd0);
        end
    endtask

    initial begin
        logic [1:0]  rsz;
        logic [31:0] raddr;

        rst = 1'b0; req_valid = 1'b0; is_write = 1'b0; size = 2'd0; sign_ext = 1'b0;
        addr = 32'd0; wdata = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        model_load = 32'd0;
        #1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_flags", {28'd0, load_valid, mem_stall, align_err, bus_timeout}, 32'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // Directed: signed byte load from the top lane
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 32'h80FF_FF12, 0, 1'b0);
        check("lb_signed_result", load_data, 32'hFFFF_FF80);
        // Directed: halfword store to upper half
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 0, 1'b0);
        // Directed: misaligned word load
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'd0, 32'd0, 0, 1'b0);
        // Directed: reserved size
        run_txn(1'b0, 2'd3, 1'b0, 32'h0000_3000, 32'd0, 32'd0, 0, 1'b0);
        // Directed: timeout with no ack, then ack on the very last allowed cycle
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'd0, 32'h1234_5678, int'(TO), 1'b0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h0000_4002, 32'd0, 32'h8765_4321, int'(TO) - 1, 1'b1);
        check("ack_on_last_cycle", load_data, 32'h0000_8765);

        // Directed: reset during the 2nd ACCESS cycle of a slow access
        req_valid = 1'b1; is_write = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h0000_5000;
        #1;
        check("rst_case_accept", 32'(mem_stall), 32'd1);
        step();
        step();
        check("rst_case_acc2_req", 32'(dmem_req), 32'd1);
        rst = 1'b0;
        #1;
        model_load = 32'd0;
        check("rst_mid_req_drop", 32'(dmem_req), 32'd0);
        check("rst_mid_stall_drop", 32'(mem_stall), 32'd0);
        check("rst_mid_load_data", load_data, 32'd0);
        check("rst_mid_be", 32'(dmem_be), 32'd0);
        req_valid = 1'b0;
        #1;
        rst = 1'b1;
        step();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_ack = 1'b0;
        check("late_ack_no_req", 32'(dmem_req), 32'd0);
        check("late_ack_no_lv", 32'(load_valid), 32'd0);
        check("late_ack_data", load_data, 32'd0);

        // Random traffic, mostly aligned, some back-to-back
        for (int t = 0; t < 80; t++) begin
            rsz = 2'($urandom_range(0, 3));
            raddr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rsz == 2'd1) raddr[0] = 1'b0;
                if (rsz == 2'd2) raddr[1:0] = 2'b00;
            end
            run_txn(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), raddr,
                    $urandom, $urandom, int'($urandom_range(0, 5)),
                    1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
